// File: rtl/fetch_unit.sv
// fetch_unit: two-byte instruction fetch stage (opcode, then operand) feeding
// the decoder over a valid/ready handshake, with branch redirect and HALT stop.
module fetch_unit #(
    parameter int unsigned             ADDR_W   = 8,
    parameter int unsigned             DATA_W   = 8,
    parameter logic [ADDR_W-1:0]       RESET_PC = 8'h00,
    parameter logic [DATA_W-1:0]       HALT_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] laddr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              halted
);

    localparam logic [1:0] S_OP    = 2'd0;
    localparam logic [1:0] S_ARG   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [DATA_W-1:0] opcode_q,      opcode_d;
    logic [DATA_W-1:0] operand_q,     operand_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q,      halted_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              take_instr;

    // Next PC wraps modulo 2**ADDR_W; a handshake in S_VALID consumes the instruction.
    always_comb begin
        pc_inc     = pc_q + ADDR_W'(1);
        take_instr = (state_q == S_VALID) && instr_ready;
    end

    // Next-state and datapath: one memory byte per edge, branch discards partial work.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            S_OP: begin
                if (branch_en) begin
                    pc_d    = branch_addr;
                    state_d = S_OP;
                end else begin
                    opcode_d   = mem_dout;
                    instr_pc_d = pc_q;
                    pc_d       = pc_inc;
                    state_d    = S_ARG;
                end
            end
            S_ARG: begin
                if (branch_en) begin
                    pc_d    = branch_addr;
                    state_d = S_OP;
                end else begin
                    operand_d = mem_dout;
                    pc_d      = pc_inc;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                // A consumed HALT takes priority over a same-edge redirect.
                if (take_instr && (opcode_q == HALT_OP)) begin
                    state_d = S_HALT;
                end else if (branch_en) begin
                    pc_d    = branch_addr;
                    state_d = S_OP;
                end else if (take_instr) begin
                    state_d = S_OP;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_OP;
            end
        endcase
        instr_valid_d = (state_d == S_VALID);
        halted_d      = (state_d == S_HALT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_OP;
            pc_q          <= RESET_PC;
            opcode_q      <= '0;
            operand_q     <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // Output mapping; the read address is the PC itself.
    always_comb begin
        laddr       = pc_q;
        instr_valid = instr_valid_q;
        opcode      = opcode_q;
        operand     = operand_q;
        instr_pc    = instr_pc_q;
        halted      = halted_q;
    end

endmodule
